pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Fetch-side program-counter stage that consumes the branch comparator's take_branch decision and the EX-stage jump controls.
- Holds the architectural fetch PC and selects sequential, branch, JAL or JALR next-PC.
- Generates pipeline flushes on a redirect.
- Parks a redirect in a PENDING state while instruction memory is not ready.
- Counts taken redirects for performance monitoring.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the saturating redirect counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_ready  in  1  instruction memory accepts pc_out this cycle.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_jal  in  1  EX instruction is JAL.
- ex_jalr  in  1  EX instruction is JALR.
- take_branch  in  1  branch comparator decision for the EX instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_imm  in  XLEN  sign-extended immediate of the EX instruction.
- ex_rs1  in  XLEN  forwarded rs1 value, used by JALR.
- pc_out  out  XLEN  current fetch PC.
- pc_plus4  out  XLEN  pc_out + 4, wrapping modulo 2^XLEN.
- flush_if_id  out  1  kill the IF/ID register.
- flush_id_ex  out  1  kill the ID/EX register.
- misaligned_exc  out  1  one-cycle pulse: redirect target is misaligned.
- redirect_cnt  out  CNT_W  number of redirects applied, saturating.

Behaviour:
- Reset (async, rst=1):
  - pc_out=RESET_PC; state=IDLE; pend_tgt=0; redirect_cnt=0; misaligned_exc=0.
  - flush_if_id=0 and flush_id_ex=0 while rst=1.
- Redirect request (combinational):
  - req = ex_valid & (ex_jal | ex_jalr | (ex_branch & take_branch)) & (state==IDLE).
  - take_branch is ignored unless ex_branch=1.
  - If more than one of ex_branch, ex_jal, ex_jalr is high, the priority is jalr > jal > branch.
- Target (modulo 2^XLEN):
  - branch and JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) with bit0 forced to 0.
- Misalignment:
  - If req=1 and target[1]=1, the redirect is suppressed: no PC change, no flush, no count.
  - misaligned_exc is registered high for exactly the next cycle.
- State IDLE:
  - req & imem_ready: pc_out <= target; flush_if_id = flush_id_ex = 1 this cycle; redirect_cnt increments; stay IDLE.
  - req & !imem_ready: pend_tgt <= target; flush_if_id = flush_id_ex = 1 this cycle; go to PENDING; pc_out holds.
  - No req & imem_ready: pc_out <= pc_out + 4.
  - No req & !imem_ready: pc_out holds.
- State PENDING:
  - flush_if_id = flush_id_ex = 1 every cycle.
  - All ex_* inputs are ignored; they are wrong-path.
  - pc_out holds until imem_ready=1, then pc_out <= pend_tgt; redirect_cnt increments; go to IDLE.
  - The flushes are still asserted in that cycle.
- Counter: redirect_cnt saturates at all-ones and never wraps.
- PC wrap-around: 32'hFFFF_FFFC + 4 gives 0 with no error.
- Latency: a redirect is visible on pc_out 1 cycle after req if imem_ready=1; otherwise 1 cycle after the first imem_ready=1.
- Reset asserted mid-PENDING: the pending target is discarded and pc_out=RESET_PC immediately.

Decomposition:
- Shared package holds:
  - XLEN.
  - RESET_PC default.
  - State encoding typedef (IDLE=1'b0, PENDING=1'b1).
  - Constant PC_STEP=4.
- One sub-module: pc_target_calc, purely combinational. It covers target select, JALR bit0 clear and the misalignment check.
- The state register, PC register, counter and flush logic stay in pc_next_unit.

Test Plan:
- Reset then 3 cycles with imem_ready=1 and no req -> pc_out sequence 0x0, 0x4, 0x8, 0xC; flushes stay 0.
- Taken BEQ: ex_pc=0x100, ex_imm=0x20, take_branch=1, imem_ready=1 -> both flushes high that cycle; pc_out=0x120 next cycle; redirect_cnt=1.
- Not-taken branch: take_branch=0, ex_branch=1 -> pc_out keeps +4 stepping; no flush; redirect_cnt unchanged.
- JALR: ex_rs1=0x2001, ex_imm=0x4 with imem_ready=0 for 3 cycles -> PENDING; flushes high for 4 cycles; pc_out holds; pc_out=0x2004 after imem_ready rises. A spurious ex_jal during PENDING is ignored.
- Misaligned JAL: ex_pc=0x10, ex_imm=0x6 -> no redirect, no flush; misaligned_exc=1 for exactly one cycle; pc_out continues +4.
- rst pulsed while in PENDING -> pc_out=RESET_PC immediately; state IDLE; redirect_cnt=0; the old target is never loaded.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// Shared types and constants for the fetch-side next-PC unit.
// Imported by the interface, the target calculator and the top.
package pc_next_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;
endpackage

// File: rtl/pc_next_unit_if.sv
// EX-side redirect controls, imem handshake and fetch-PC outputs.
// master drives the EX controls; slave is the next-PC unit.
interface pc_next_unit_if
  import pc_next_unit_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             imem_ready;
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_jal;
  logic             ex_jalr;
  logic             take_branch;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  pc_out;
  logic [XLEN-1:0]  pc_plus4;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             misaligned_exc;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output imem_ready, ex_valid, ex_branch,
    output ex_jal, ex_jalr, take_branch,
    output ex_pc, ex_imm, ex_rs1,
    input  pc_out, pc_plus4, flush_if_id,
    input  flush_id_ex, misaligned_exc,
    input  redirect_cnt
  );

  modport slave (
    input  imem_ready, ex_valid, ex_branch,
    input  ex_jal, ex_jalr, take_branch,
    input  ex_pc, ex_imm, ex_rs1,
    output pc_out, pc_plus4, flush_if_id,
    output flush_id_ex, misaligned_exc,
    output redirect_cnt
  );
endinterface

// File: rtl/pc_next_unit_pc_target_calc.sv
// Redirect target select, JALR bit0 clear and alignment check.
// Purely combinational; state gating lives in the caller.
module pc_target_calc
  import pc_next_unit_pkg::*;
(
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic            ex_jal_i,
  input  logic            ex_jalr_i,
  input  logic            take_branch_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  output logic            req_o,
  output logic [XLEN-1:0] tgt_o,
  output logic            misal_o
);
  logic [XLEN-1:0] sum;

  always_comb begin
    sum = ex_pc_i + ex_imm_i;
    unique case (1'b1)
      ex_jalr_i: begin
        sum = ex_rs1_i + ex_imm_i;
        sum[0] = 1'b0;
      end
      default: ;
    endcase
  end

  assign req_o = ex_valid_i
               & (ex_jal_i | ex_jalr_i
                  | (ex_branch_i & take_branch_i));
  assign tgt_o   = sum;
  assign misal_o = sum[1];
endmodule

// File: rtl/pc_next_unit.sv
// Fetch PC register with branch/JAL/JALR redirect, flush
// generation, imem-stall parking and a saturating redirect count.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              CNT_W    = 32
)(
  input  logic           clk,
  input  logic           rst,
  pc_next_unit_if.slave  bus
);
  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exc_q, exc_d;
  logic             raw_req, req, go, inc, misal;
  logic [XLEN-1:0]  tgt, pc_inc;

  pc_target_calc u_calc (
    .ex_valid_i    (bus.ex_valid),
    .ex_branch_i   (bus.ex_branch),
    .ex_jal_i      (bus.ex_jal),
    .ex_jalr_i     (bus.ex_jalr),
    .take_branch_i (bus.take_branch),
    .ex_pc_i       (bus.ex_pc),
    .ex_imm_i      (bus.ex_imm),
    .ex_rs1_i      (bus.ex_rs1),
    .req_o         (raw_req),
    .tgt_o         (tgt),
    .misal_o       (misal)
  );

  assign pc_inc = pc_q + PC_STEP;
  assign req    = raw_req & (state_q == IDLE);
  assign go     = req & ~misal;
  assign exc_d  = req & misal;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go && bus.imem_ready) begin
          pc_d = tgt;
          inc  = 1'b1;
        end else if (go) begin
          pend_d  = tgt;
          state_d = PENDING;
        end else if (bus.imem_ready) begin
          pc_d = pc_inc;
        end
      end
      PENDING: begin
        if (bus.imem_ready) begin
          pc_d    = pend_q;
          inc     = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  // Flushes are combinational so the wrong-path fetch dies this cycle.
  assign bus.flush_if_id = ~rst & (go | (state_q == PENDING));
  assign bus.flush_id_ex = ~rst & (go | (state_q == PENDING));
  assign bus.pc_out         = pc_q;
  assign bus.pc_plus4       = pc_inc;
  assign bus.misaligned_exc = exc_q;
  assign bus.redirect_cnt   = cnt_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit.
// Counter narrowed to 3 bits so saturation is reachable.
module tb_pc_next_unit;
  import pc_next_unit_pkg::*;

  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  pc_next_unit_if #(.CNT_W(CW)) bus ();

  pc_next_unit #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.ex_valid    = 1'b0;
    bus.ex_branch   = 1'b0;
    bus.ex_jal      = 1'b0;
    bus.ex_jalr     = 1'b0;
    bus.take_branch = 1'b0;
    bus.ex_pc       = '0;
    bus.ex_imm      = '0;
    bus.ex_rs1      = '0;
  endtask

  task automatic fl(input string tag, input logic exp);
    #1;
    chk({tag, "_fif"}, 32'(bus.flush_if_id), 32'(exp));
    chk({tag, "_fex"}, 32'(bus.flush_id_ex), 32'(exp));
  endtask

  initial begin
    clr();
    bus.imem_ready = 1'b0;
    // Reset with a live JAL on the inputs: no flush while rst=1
    bus.ex_valid = 1'b1;
    bus.ex_jal   = 1'b1;
    bus.ex_imm   = 32'h8;
    #2;
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_cnt", 32'(bus.redirect_cnt), 32'h0);
    chk("rst_exc", 32'(bus.misaligned_exc), 32'h0);
    fl("rst", 1'b0);
    clr();
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    #1;
    chk("seq0", bus.pc_out, 32'h0);
    chk("seq0_p4", bus.pc_plus4, 32'h4);
    tick(); chk("seq1", bus.pc_out, 32'h4);
    tick(); chk("seq2", bus.pc_out, 32'h8);
    tick(); chk("seq3", bus.pc_out, 32'hC);
    fl("seq", 1'b0);

    // Taken BEQ
    bus.ex_valid = 1'b1; bus.ex_branch = 1'b1;
    bus.take_branch = 1'b1;
    bus.ex_pc = 32'h100; bus.ex_imm = 32'h20;
    fl("beq", 1'b1);
    tick(); clr();
    chk("beq_pc", bus.pc_out, 32'h120);
    chk("beq_cnt", 32'(bus.redirect_cnt), 32'h1);
    fl("beq_after", 1'b0);

    // Not-taken branch
    bus.ex_valid = 1'b1; bus.ex_branch = 1'b1;
    bus.ex_pc = 32'h200; bus.ex_imm = 32'h40;
    fl("nt", 1'b0);
    tick();
    chk("nt_pc", bus.pc_out, 32'h124);
    chk("nt_cnt", 32'(bus.redirect_cnt), 32'h1);
    // take_branch without ex_branch is ignored
    bus.ex_branch = 1'b0; bus.take_branch = 1'b1;
    fl("tbonly", 1'b0);
    tick(); clr();
    chk("tbonly_pc", bus.pc_out, 32'h128);

    // JALR stalled by imem for 3 cycles
    bus.imem_ready = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_jalr = 1'b1;
    bus.ex_rs1 = 32'h2001; bus.ex_imm = 32'h4;
    fl("jalr_c1", 1'b1);
    tick(); clr();
    bus.ex_valid = 1'b1; bus.ex_jal = 1'b1;
    bus.ex_pc = 32'h0; bus.ex_imm = 32'h40;
    fl("jalr_c2", 1'b1);
    chk("jalr_c2_pc", bus.pc_out, 32'h128);
    tick();
    fl("jalr_c3", 1'b1);
    chk("jalr_c3_pc", bus.pc_out, 32'h128);
    tick();
    bus.imem_ready = 1'b1;
    fl("jalr_c4", 1'b1);
    chk("jalr_c4_pc", bus.pc_out, 32'h128);
    tick(); clr();
    chk("jalr_pc", bus.pc_out, 32'h2004);
    chk("jalr_cnt", 32'(bus.redirect_cnt), 32'h2);
    fl("jalr_after", 1'b0);

    // Misaligned JAL: 0x10+0x6=0x16
    bus.ex_valid = 1'b1; bus.ex_jal = 1'b1;
    bus.ex_pc = 32'h10; bus.ex_imm = 32'h6;
    fl("mis", 1'b0);
    chk("mis_exc0", 32'(bus.misaligned_exc), 32'h0);
    tick(); clr();
    chk("mis_pc", bus.pc_out, 32'h2008);
    chk("mis_exc1", 32'(bus.misaligned_exc), 32'h1);
    chk("mis_cnt", 32'(bus.redirect_cnt), 32'h2);
    tick();
    chk("mis_exc2", 32'(bus.misaligned_exc), 32'h0);
    chk("mis_pc2", bus.pc_out, 32'h200C);

    // JAL without ex_valid does nothing
    bus.ex_jal = 1'b1; bus.ex_imm = 32'h40;
    fl("nov", 1'b0);
    tick(); clr();
    chk("nov_pc", bus.pc_out, 32'h2010);

    // jalr wins over jal: 0x400+0x10
    bus.ex_valid = 1'b1; bus.ex_jal = 1'b1; bus.ex_jalr = 1'b1;
    bus.ex_pc = 32'h300; bus.ex_rs1 = 32'h400;
    bus.ex_imm = 32'h10;
    tick(); clr();
    chk("prio_pc", bus.pc_out, 32'h410);
    chk("prio_cnt", 32'(bus.redirect_cnt), 32'h3);

    // PC wrap-around
    bus.ex_valid = 1'b1; bus.ex_jalr = 1'b1;
    bus.ex_rs1 = 32'hFFFF_FFF8; bus.ex_imm = 32'h4;
    tick(); clr();
    chk("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    chk("wrap_p4", bus.pc_plus4, 32'h0);
    chk("wrap_cnt", 32'(bus.redirect_cnt), 32'h4);
    tick();
    chk("wrap_pc2", bus.pc_out, 32'h0);

    // Counter saturates at 7
    for (int k = 5; k <= 9; k++) begin
      bus.ex_valid = 1'b1; bus.ex_jal = 1'b1;
      bus.ex_pc = 32'h0; bus.ex_imm = 32'h40;
      tick(); clr();
      chk("sat_cnt", 32'(bus.redirect_cnt),
          (k > 7) ? 32'h7 : 32'(k));
    end
    chk("sat_pc", bus.pc_out, 32'h40);

    // Reset in the middle of PENDING
    bus.imem_ready = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_jal = 1'b1;
    bus.ex_pc = 32'h40; bus.ex_imm = 32'h80;
    tick(); clr();
    fl("pend", 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_pc", bus.pc_out, 32'h0);
    chk("mrst_cnt", 32'(bus.redirect_cnt), 32'h0);
    fl("mrst", 1'b0);
    bus.imem_ready = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    fl("mrst_idle", 1'b0);
    chk("mrst_pc1", bus.pc_out, 32'h0);
    tick();
    chk("mrst_pc2", bus.pc_out, 32'h4);
    chk("mrst_cnt2", 32'(bus.redirect_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
